// File: rtl/load_store_unit_if.sv
// Core/memory-facing bus of the load/store unit.
//   req_*  : sized, byte-addressed request from the core (valid/ready handshake)
//   resp_* : one-cycle completion pulse with error flag and load data
//   mem_*  : word-wide synchronous block-RAM port (mem_rw: 1 = read, 0 = write)
// slave  : the load/store unit itself.
// master : the environment, which is both the core and the memory.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rw;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_err, resp_rdata,
        output mem_addr, mem_wdata, mem_wmask, mem_rw
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_err, resp_rdata,
        input  mem_addr, mem_wdata, mem_wmask, mem_rw
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit between a multi-cycle RV32I core and a word-wide synchronous block RAM.
// Turns byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into aligned word accesses with a
// byte write mask and extracts/extends load data. Misaligned, out-of-range or illegal
// requests complete with resp_err without touching memory. One request in flight.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous, active-high
//   bus   : load_store_unit_if.slave (request, response and memory signals)
// All bus outputs are registered.
module load_store_unit #(
    parameter int unsigned MEM_BYTES  = 1024,
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset,
    load_store_unit_if.slave bus
);

    localparam logic [32:0] MemLimit = 33'(MEM_BYTES);

    typedef enum logic [1:0] {StIdle, StAccess, StLoadWait, StResp} state_e;

    state_e state_q, state_d;

    logic [1:0]  addr_lo_q,    addr_lo_d;
    logic [2:0]  funct3_q,     funct3_d;
    logic        we_q,         we_d;
    logic        req_ready_q,  req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q,   resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic [31:0] mem_addr_q,   mem_addr_d;
    logic [31:0] mem_wdata_q,  mem_wdata_d;
    logic [3:0]  mem_wmask_q,  mem_wmask_d;
    logic        mem_rw_q,     mem_rw_d;

    logic        accept;
    logic [2:0]  size;
    logic        f3_legal;
    logic        misaligned;
    logic        out_of_range;
    logic        req_err;
    logic [32:0] last_byte;
    logic [31:0] shifted;
    logic [31:0] load_ext;

    // req_ready_q is high exactly in IDLE
    assign accept = bus.req_valid && req_ready_q;

    // Request legality, evaluated on the incoming request
    always_comb begin
        size     = 3'd1;
        f3_legal = 1'b1;
        case (bus.req_funct3)
            3'd0, 3'd4: size = 3'd1;
            3'd1, 3'd5: size = 3'd2;
            3'd2:       size = 3'd4;
            default: begin
                size     = 3'd1;
                f3_legal = 1'b0;
            end
        endcase
        // Stores have no unsigned variants
        if (bus.req_we && bus.req_funct3[2]) begin
            f3_legal = 1'b0;
        end
        misaligned = ((size == 3'd2) && bus.req_addr[0]) ||
                     ((size == 3'd4) && (bus.req_addr[1:0] != 2'b00));
        // 33-bit sum so a wrap past 0xFFFFFFFF lands above the limit
        last_byte    = {1'b0, bus.req_addr} + {30'b0, size} - 33'd1;
        out_of_range = ({1'b0, bus.req_addr} >= MemLimit) || (last_byte >= MemLimit);
        req_err      = !f3_legal || misaligned || out_of_range;
    end

    // Load extraction from the registered memory word
    always_comb begin
        shifted = bus.mem_rdata >> {addr_lo_q, 3'b000};
        case (funct3_q)
            3'd0:    load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'd1:    load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'd4:    load_ext = {24'b0, shifted[7:0]};
            3'd5:    load_ext = {16'b0, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = req_err ? StResp : StAccess;
                end
            end
            StAccess:   state_d = we_q ? StResp : StLoadWait;
            StLoadWait: state_d = StResp;
            StResp:     state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs and request context
    always_comb begin
        addr_lo_d    = addr_lo_q;
        funct3_d     = funct3_q;
        we_d         = we_q;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wmask_d  = mem_wmask_q;
        mem_rw_d     = mem_rw_q;
        req_ready_d  = (state_d == StIdle);
        resp_valid_d = (state_d == StResp);

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (req_err) begin
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'h0;
                    end else begin
                        addr_lo_d  = bus.req_addr[1:0];
                        funct3_d   = bus.req_funct3;
                        we_d       = bus.req_we;
                        mem_addr_d = {bus.req_addr[31:2], 2'b00};
                        if (bus.req_we) begin
                            mem_rw_d = 1'b0;
                            case (bus.req_funct3[1:0])
                                2'd0: begin
                                    mem_wdata_d = {4{bus.req_wdata[7:0]}};
                                    mem_wmask_d = 4'b0001 << bus.req_addr[1:0];
                                end
                                2'd1: begin
                                    mem_wdata_d = {2{bus.req_wdata[15:0]}};
                                    mem_wmask_d = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                                end
                                default: begin
                                    mem_wdata_d = bus.req_wdata;
                                    mem_wmask_d = 4'b1111;
                                end
                            endcase
                        end else begin
                            mem_rw_d    = 1'b1;
                            mem_wmask_d = 4'b0000;
                        end
                    end
                end
            end
            StAccess: begin
                // Memory acts on this edge; drop the write strobe afterwards
                mem_rw_d    = 1'b1;
                mem_wmask_d = 4'b0000;
                if (we_q) begin
                    resp_err_d   = 1'b0;
                    resp_rdata_d = 32'h0;
                end
            end
            StLoadWait: begin
                resp_err_d   = 1'b0;
                resp_rdata_d = load_ext;
            end
            StResp: begin
                mem_addr_d = RESET_ADDR;
            end
            default: begin
                mem_rw_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_lo_q    <= 2'b00;
            funct3_q     <= 3'd0;
            we_q         <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
            mem_addr_q   <= RESET_ADDR;
            mem_wdata_q  <= 32'h0;
            mem_wmask_q  <= 4'b0000;
            mem_rw_q     <= 1'b1;
        end else begin
            addr_lo_q    <= addr_lo_d;
            funct3_q     <= funct3_d;
            we_q         <= we_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wmask_q  <= mem_wmask_d;
            mem_rw_q     <= mem_rw_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_wmask  = mem_wmask_q;
    assign bus.mem_rw     = mem_rw_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: plays core and block RAM, pushes expected
// responses into a scoreboard queue at accept time; a monitor pops and compares.
module tb_load_store_unit;
    localparam int unsigned MemBytes = 1024;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    load_store_unit_if bus ();

    load_store_unit #(
        .MEM_BYTES  (MemBytes),
        .RESET_ADDR (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Word-wide synchronous RAM with byte enables, read data registered
    logic [31:0] mem [0:255] = '{default: 32'h0};
    always @(posedge clk) begin
        if (!bus.mem_rw) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_wmask[b]) mem[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end
        end
        bus.mem_rdata <= mem[bus.mem_addr[9:2]];
    end

    int cyc       = 0;
    int wr_cycles = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (!bus.mem_rw) wr_cycles <= wr_cycles + 1;

    typedef struct {
        string       tag;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   last_acc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every response must match the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && bus.resp_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got resp_valid=1 rdata %h expected no response",
                             bus.resp_rdata);
                end else begin
                    e = sb_q.pop_front();
                    check({e.tag, " resp_err"}, 32'(bus.resp_err), 32'(e.err));
                    check({e.tag, " resp_rdata"}, bus.resp_rdata, e.rdata);
                    check({e.tag, " latency"}, 32'(cyc - e.acc + 1), 32'(e.lat));
                end
            end
        end
    end

    task automatic issue(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic exp_err, input logic [31:0] exp_rdata,
                         input logic [3:0] exp_wmask, input logic [31:0] exp_mwdata,
                         input bit push, input bit hold);
        exp_t e;
        int   guard = 0;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        while (!bus.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.req_ready) begin
            checks++;
            errors++;
            $display("FAIL %s accept_timeout: got req_ready=0 expected 1", tag);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (!hold) bus.req_valid = 1'b0;
        last_acc = cyc;
        if (push) begin
            e.tag   = tag;
            e.err   = exp_err;
            e.rdata = exp_rdata;
            e.lat   = exp_err ? 1 : (we ? 2 : 3);
            e.acc   = cyc;
            sb_q.push_back(e);
        end
        check({tag, " req_ready"}, 32'(bus.req_ready), 32'h0);
        check({tag, " mem_rw"}, 32'(bus.mem_rw), (exp_err || !we) ? 32'h1 : 32'h0);
        check({tag, " mem_wmask"}, 32'(bus.mem_wmask),
              (exp_err || !we) ? 32'h0 : 32'(exp_wmask));
        check({tag, " mem_addr"}, bus.mem_addr, exp_err ? 32'h0 : {addr[31:2], 2'b00});
        if (!exp_err && we) check({tag, " mem_wdata"}, bus.mem_wdata, exp_mwdata);
    endtask

    task automatic drain();
        int guard = 0;
        while (sb_q.size() != 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w0;
        int r;
        int guard;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst req_ready", 32'(bus.req_ready), 32'h1);
        check("rst resp_valid", 32'(bus.resp_valid), 32'h0);
        check("rst resp_err", 32'(bus.resp_err), 32'h0);
        check("rst resp_rdata", bus.resp_rdata, 32'h0);
        check("rst mem_addr", bus.mem_addr, 32'h0);
        check("rst mem_wdata", bus.mem_wdata, 32'h0);
        check("rst mem_wmask", 32'(bus.mem_wmask), 32'h0);
        check("rst mem_rw", 32'(bus.mem_rw), 32'h1);

        // Word access round trip
        issue("sw10", 1, 3'd2, 32'h10, 32'hDEADBEEF, 0, 32'h0, 4'b1111, 32'hDEADBEEF, 1, 0);
        issue("lw10", 0, 3'd2, 32'h10, 32'h0, 0, 32'hDEADBEEF, 4'b0, 32'h0, 1, 0);
        issue("sw10z", 1, 3'd2, 32'h10, 32'h0, 0, 32'h0, 4'b1111, 32'h0, 1, 0);

        // Byte lanes
        issue("sb13", 1, 3'd0, 32'h13, 32'h000000A5, 0, 32'h0, 4'b1000, 32'hA5A5A5A5, 1, 0);
        issue("lb13", 0, 3'd0, 32'h13, 32'h0, 0, 32'hFFFFFFA5, 4'b0, 32'h0, 1, 0);
        issue("lbu13", 0, 3'd4, 32'h13, 32'h0, 0, 32'h000000A5, 4'b0, 32'h0, 1, 0);
        issue("lw10b", 0, 3'd2, 32'h10, 32'h0, 0, 32'hA5000000, 4'b0, 32'h0, 1, 0);

        // Half lanes
        issue("sh22", 1, 3'd1, 32'h22, 32'h00008001, 0, 32'h0, 4'b1100, 32'h80018001, 1, 0);
        issue("lh22", 0, 3'd1, 32'h22, 32'h0, 0, 32'hFFFF8001, 4'b0, 32'h0, 1, 0);
        issue("lhu22", 0, 3'd5, 32'h22, 32'h0, 0, 32'h00008001, 4'b0, 32'h0, 1, 0);
        drain();

        // Errors must never write memory
        w0 = wr_cycles;
        issue("lw21", 0, 3'd2, 32'h21, 32'h0, 1, 32'h0, 4'b0, 32'h0, 1, 0);
        issue("lh23", 0, 3'd1, 32'h23, 32'h0, 1, 32'h0, 4'b0, 32'h0, 1, 0);
        issue("ld_f3", 0, 3'd3, 32'h10, 32'h0, 1, 32'h0, 4'b0, 32'h0, 1, 0);
        issue("st_f4", 1, 3'd4, 32'h10, 32'hFFFFFFFF, 1, 32'h0, 4'b0, 32'h0, 1, 0);
        drain();
        check("err no_write", 32'(wr_cycles - w0), 32'h0);

        // Range boundaries
        issue("sw3fc", 1, 3'd2, MemBytes - 4, 32'h12345678, 0, 32'h0, 4'b1111, 32'h12345678, 1, 0);
        issue("lw3fc", 0, 3'd2, MemBytes - 4, 32'h0, 0, 32'h12345678, 4'b0, 32'h0, 1, 0);
        issue("lbu3ff", 0, 3'd4, MemBytes - 1, 32'h0, 0, 32'h00000012, 4'b0, 32'h0, 1, 0);
        issue("lhu3fe", 0, 3'd5, MemBytes - 2, 32'h0, 0, 32'h00001234, 4'b0, 32'h0, 1, 0);
        issue("lw400", 0, 3'd2, MemBytes, 32'h0, 1, 32'h0, 4'b0, 32'h0, 1, 0);
        issue("lb400", 0, 3'd0, MemBytes, 32'h0, 1, 32'h0, 4'b0, 32'h0, 1, 0);
        issue("lh3ff", 0, 3'd1, MemBytes - 1, 32'h0, 1, 32'h0, 4'b0, 32'h0, 1, 0);
        issue("lwwrap", 0, 3'd2, 32'hFFFFFFFC, 32'h0, 1, 32'h0, 4'b0, 32'h0, 1, 0);
        drain();

        // Reset while the load is in LOAD_WAIT: no response may follow
        issue("lw_rst", 0, 3'd2, 32'h10, 32'h0, 0, 32'h0, 4'b0, 32'h0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrst req_ready", 32'(bus.req_ready), 32'h1);
        check("midrst resp_valid", 32'(bus.resp_valid), 32'h0);
        check("midrst mem_rw", 32'(bus.mem_rw), 32'h1);
        check("midrst mem_addr", bus.mem_addr, 32'h0);
        check("midrst resp_rdata", bus.resp_rdata, 32'h0);
        repeat (4) @(negedge clk);

        // req_valid held through a busy load, then a back-to-back request
        issue("lw_hold", 0, 3'd2, 32'h10, 32'h0, 0, 32'hA5000000, 4'b0, 32'h0, 1, 1);
        guard = 0;
        while (!bus.resp_valid && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        r = cyc;
        issue("lbu_b2b", 0, 3'd4, 32'h13, 32'h0, 0, 32'h000000A5, 4'b0, 32'h0, 1, 0);
        check("b2b accept_cycle", 32'(last_acc), 32'(r + 2));
        drain();
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
